// File: rtl/rom_b_seq_pkg.sv
// rtl/rom_b_seq_pkg.sv - state codes, defaults, layer decode and ROM image for rom_b_seq
package rom_b_seq_pkg;

    localparam int STATE_LEN = 4;
    localparam logic [STATE_LEN-1:0] MIX1 = 4'h4;
    localparam logic [STATE_LEN-1:0] MIX2 = 4'h5;
    localparam logic [STATE_LEN-1:0] MIX3 = 4'h6;

    localparam int DEF_HID_DIM = 24;
    localparam int DEF_N_LEN   = 16;
    localparam int DEF_LEAD    = 8;
    localparam int DEF_STRIDE  = 4;
    localparam int DEF_PERIOD  = 101;

    typedef struct packed {
        logic                 valid;
        logic [STATE_LEN-1:0] idx;
    } layer_t;

    // MIX codes are contiguous from MIX1, so MIXn decodes to layer n-1.
    function automatic layer_t layer_decode(input logic [STATE_LEN-1:0] st, input int n_layers);
        layer_t r;
        int     d;
        d       = 32'(st) - 32'(MIX1);
        r.valid = (d >= 0) && (d < n_layers);
        r.idx   = r.valid ? STATE_LEN'(d) : '0;
        return r;
    endfunction

    function automatic logic layer_valid(input logic [STATE_LEN-1:0] st, input int n_layers);
        layer_t r;
        r = layer_decode(st, n_layers);
        return r.valid;
    endfunction

    // Bias image: entry index in the upper byte, file-dependent pattern below.
    function automatic logic [31:0] rom_word(input int filenum, input int idx);
        return (32'(idx) << 8) | ((32'(idx) * 32'd7 + 32'd90 + 32'(filenum)) & 32'hFF);
    endfunction

endpackage

// File: rtl/rom_b_seq_core.sv
// rtl/rom_b_seq_core.sv - synchronous bias ROM with registered, enable-held output
module rom_b_seq_core
    import rom_b_seq_pkg::*;
#(
    parameter int FILENUM = 0,
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 8,
    parameter int DEPTH   = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_en,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] o_data
);

    logic [DATA_W-1:0] w_word;
    logic [DATA_W-1:0] r_data;

    always_comb begin
        w_word = '0;
        if (32'(i_addr) < 32'(DEPTH)) begin
            w_word = DATA_W'(rom_word(FILENUM, 32'(i_addr)));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
        end else if (i_en) begin
            r_data <= w_word;
        end
    end

    assign o_data = r_data;

endmodule

// File: rtl/rom_b_seq.sv
// rtl/rom_b_seq.sv - bias-ROM address sequencer for the mix layer
// Option macro ROM_B_LAYER_OFFSET_EN: one shared ROM holding all layers, addressed at layer*HID_DIM + k.
module rom_b_seq
    import rom_b_seq_pkg::*;
#(
    parameter int FILENUM  = 0,
    parameter int DATA_W   = DEF_N_LEN,
    parameter int ADDR_W   = 8,
    parameter int HID_DIM  = DEF_HID_DIM,
    parameter int N_LAYERS = 3,
    parameter int LEAD     = DEF_LEAD,
    parameter int STRIDE   = DEF_STRIDE,
    parameter int PERIOD   = DEF_PERIOD
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 run,
    input  logic [STATE_LEN-1:0] state,
    output logic [DATA_W-1:0]    output_bias,
    output logic                 bias_valid,
    output logic                 seq_done,
    output logic                 state_err
);

    localparam int CNT_W = $clog2(PERIOD + 1);
    localparam int K_W   = (HID_DIM > 1) ? $clog2(HID_DIM) : 1;
    localparam logic [K_W-1:0] K_LAST = K_W'(HID_DIM - 1);
`ifdef ROM_B_LAYER_OFFSET_EN
    localparam int DEPTH = N_LAYERS * HID_DIM;
`else
    localparam int DEPTH = HID_DIM;
`endif

    if (PERIOD < LEAD + (HID_DIM - 1) * STRIDE) begin : g_bad_period
        $error("rom_b_seq: PERIOD shorter than the bias walk");
    end
    if (ADDR_W < $clog2(DEPTH)) begin : g_bad_addr_w
        $error("rom_b_seq: ADDR_W too narrow for the ROM depth");
    end

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} fsm_t;

    fsm_t              r_fsm;
    logic [CNT_W-1:0]  r_cnt;
    logic [K_W-1:0]    r_k;
    logic [ADDR_W-1:0] r_addr;
    logic              r_stepped;
    logic              r_valid;
    logic              r_done;
    logic              r_err;

    logic              w_state_ok;
    logic [ADDR_W-1:0] w_base;
    logic              w_err;
    logic              w_wrap;
    logic [31:0]       w_step_at;
    logic              w_step;
    logic [K_W-1:0]    w_k_next;
    logic              w_sat;
    logic              w_fetch;
`ifdef ROM_B_LAYER_OFFSET_EN
    layer_t            w_layer;
`endif

    always_comb begin
        w_base = '0;
`ifdef ROM_B_LAYER_OFFSET_EN
        w_layer    = layer_decode(state, N_LAYERS);
        w_state_ok = w_layer.valid;
        if (w_layer.valid) begin
            w_base = ADDR_W'(32'(w_layer.idx) * 32'(HID_DIM));
        end
`else
        w_state_ok = layer_valid(state, N_LAYERS);
`endif
        w_err     = run & ~w_state_ok;
        w_wrap    = run && (r_cnt == CNT_W'(PERIOD));
        w_step_at = 32'(LEAD) + 32'(r_k) * 32'(STRIDE);
        w_step    = run && !w_wrap && (r_fsm != S_DONE) && (r_k < K_LAST)
                    && (32'(r_cnt) == w_step_at);
        w_k_next  = w_step ? (r_k + K_W'(1)) : r_k;
        w_sat     = (w_k_next == K_LAST);
        // A fresh address sits on r_addr at cnt==0 (run start or wrap) and right after each step.
        w_fetch   = run && ((r_cnt == '0) || r_stepped);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fsm     <= S_IDLE;
            r_cnt     <= '0;
            r_k       <= '0;
            r_addr    <= '0;
            r_stepped <= 1'b0;
            r_valid   <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_valid   <= w_fetch & ~w_err;
            r_err     <= w_err;
            r_stepped <= w_step;
            if (!run) begin
                r_fsm  <= S_IDLE;
                r_cnt  <= '0;
                r_k    <= '0;
                r_addr <= w_base;
                r_done <= 1'b0;
            end else if (w_wrap) begin
                r_fsm  <= S_RUN;
                r_cnt  <= '0;
                r_k    <= '0;
                r_addr <= w_base;
                r_done <= 1'b0;
            end else begin
                r_cnt  <= r_cnt + CNT_W'(1);
                r_k    <= w_k_next;
                r_done <= w_sat;
                r_fsm  <= w_sat ? S_DONE : S_RUN;
                if (w_step) begin
                    r_addr <= r_addr + ADDR_W'(1);
                end
            end
        end
    end

    rom_b_seq_core #(
        .FILENUM (FILENUM),
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .DEPTH   (DEPTH)
    ) u_core (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_en   (w_fetch & ~w_err),
        .i_addr (r_addr),
        .o_data (output_bias)
    );

    assign bias_valid = r_valid;
    assign seq_done   = r_done;
    assign state_err  = r_err;

endmodule

// File: tb/tb_rom_b_seq.sv
// tb/tb_rom_b_seq.sv - randomized self-checking bench for rom_b_seq against a positional reference model
module tb_rom_b_seq;
    import rom_b_seq_pkg::*;

    localparam int FILENUM   = 0;
    localparam int DATA_W    = 16;
    localparam int ADDR_W    = 8;
    localparam int HID_DIM   = 24;
    localparam int N_LAYERS  = 3;
    localparam int LEAD      = 8;
    localparam int STRIDE    = 4;
    localparam int PERIOD    = 101;
    localparam int LAST_STEP = LEAD + (HID_DIM - 2) * STRIDE;

    logic                 clk   = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 run   = 1'b0;
    logic [STATE_LEN-1:0] state = MIX1;
    logic [DATA_W-1:0]    output_bias;
    logic                 bias_valid;
    logic                 seq_done;
    logic                 state_err;

    int n_checks = 0;
    int n_fail   = 0;

    int m_cnt  = 0;
    int m_base = 0;
    int m_bias = 0;
    bit m_valid = 0;
    bit m_done  = 0;
    bit m_err   = 0;

    rom_b_seq #(
        .FILENUM  (FILENUM),
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .HID_DIM  (HID_DIM),
        .N_LAYERS (N_LAYERS),
        .LEAD     (LEAD),
        .STRIDE   (STRIDE),
        .PERIOD   (PERIOD)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .run         (run),
        .state       (state),
        .output_bias (output_bias),
        .bias_valid  (bias_valid),
        .seq_done    (seq_done),
        .state_err   (state_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, want, $time);
        end
    endtask

    function automatic int ref_word(input int a);
        return (a * 256 + ((a * 7 + 90 + FILENUM) % 256)) % 65536;
    endfunction

    function automatic bit ref_valid(input logic [STATE_LEN-1:0] st);
        return (st == MIX1) || (st == MIX2) || (st == MIX3);
    endfunction

    function automatic int ref_base(input logic [STATE_LEN-1:0] st);
`ifdef ROM_B_LAYER_OFFSET_EN
        if (st == MIX2) return HID_DIM;
        if (st == MIX3) return 2 * HID_DIM;
        return 0;
`else
        return (st == MIX1) ? 0 : 0;
`endif
    endfunction

    // Expected outputs after one clock edge, from the position p within the period.
    task automatic model_edge(input bit r, input logic [STATE_LEN-1:0] st);
        int p;
        int e;
        bit v;
        p = m_cnt;
        e = 0;
        v = ref_valid(st);
        m_err = r && !v;
        if (r) begin
            m_valid = 1'b0;
            if (p == 0) begin
                m_valid = v;
            end else if (p > LEAD && (p - 1 - LEAD) % STRIDE == 0 && (p - 1 - LEAD) / STRIDE <= HID_DIM - 2) begin
                m_valid = v;
                e = (p - 1 - LEAD) / STRIDE + 1;
            end
            if (m_valid) m_bias = ref_word(m_base + e);
            m_done = (p >= LAST_STEP) && (p != PERIOD);
            if (p == PERIOD) begin
                m_cnt  = 0;
                m_base = ref_base(st);
            end else begin
                m_cnt = p + 1;
            end
        end else begin
            m_valid = 1'b0;
            m_done  = 1'b0;
            m_cnt   = 0;
            m_base  = ref_base(st);
        end
    endtask

    task automatic compare(input string tag);
        chk_eq({tag, ".valid"}, 32'(bias_valid), 32'(m_valid));
        chk_eq({tag, ".bias"},  32'(output_bias), m_bias);
        chk_eq({tag, ".done"},  32'(seq_done), 32'(m_done));
        chk_eq({tag, ".err"},   32'(state_err), 32'(m_err));
    endtask

    task automatic step_cycle(input string tag, input bit r, input logic [STATE_LEN-1:0] st);
        run   = r;
        state = st;
        @(posedge clk);
        model_edge(r, st);
        #1;
        compare(tag);
        @(negedge clk);
    endtask

    task automatic run_seg(input string tag, input bit r, input logic [STATE_LEN-1:0] st, input int n);
        for (int i = 0; i < n; i++) step_cycle(tag, r, st);
    endtask

    task automatic do_reset(input string tag);
        #2;
        rst_n = 1'b0;
        run   = 1'b0;
        #1;
        chk_eq({tag, ".bias"},  32'(output_bias), 32'd0);
        chk_eq({tag, ".valid"}, 32'(bias_valid), 32'd0);
        chk_eq({tag, ".done"},  32'(seq_done), 32'd0);
        chk_eq({tag, ".err"},   32'(state_err), 32'd0);
        m_cnt = 0; m_base = 0; m_bias = 0;
        m_valid = 1'b0; m_done = 1'b0; m_err = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [STATE_LEN-1:0] pick_state();
        int r;
        r = $urandom_range(0, 9);
        if (r < 3) return MIX1;
        if (r < 6) return MIX2;
        if (r < 9) return MIX3;
        return STATE_LEN'($urandom_range(0, 15));
    endfunction

    initial begin
        logic [STATE_LEN-1:0] st;
        int len;
        int idle;

        repeat (2) @(negedge clk);
        chk_eq("reset.bias",  32'(output_bias), 32'd0);
        chk_eq("reset.valid", 32'(bias_valid), 32'd0);
        chk_eq("reset.done",  32'(seq_done), 32'd0);
        chk_eq("reset.err",   32'(state_err), 32'd0);
        rst_n = 1'b1;

        run_seg("walk_mix1", 1'b1, MIX1, 210);
        run_seg("idle", 1'b0, MIX3, 3);
        run_seg("walk_mix3", 1'b1, MIX3, 110);
        run_seg("bad_state", 1'b1, 4'h0, 15);
        run_seg("bad_state_f", 1'b1, 4'hF, 15);
        run_seg("recover_mix2", 1'b1, MIX2, 130);
        run_seg("idle", 1'b0, MIX1, 2);
        run_seg("pre_reset", 1'b1, MIX1, 50);
        do_reset("async_reset");
        run_seg("post_reset", 1'b1, MIX1, 30);
        run_seg("idle", 1'b0, MIX1, 1);
        run_seg("pre_drop", 1'b1, MIX2, 40);
        run_seg("drop", 1'b0, MIX2, 1);
        run_seg("after_drop", 1'b1, MIX2, 110);

        for (int s = 0; s < 30; s++) begin
            idle = $urandom_range(0, 3);
            len  = $urandom_range(1, 230);
            st   = pick_state();
            run_seg("rnd_idle", 1'b0, st, idle);
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 99) < 2) st = pick_state();
                step_cycle("rnd_run", 1'b1, st);
            end
            if ($urandom_range(0, 9) == 0) do_reset("rnd_reset");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
